// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared state encoding and default sizing for the multiplier scheduler
package mult_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        FIRE  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam int MBITS_DEF    = 12;
    localparam int NBITS_DEF    = 8;
    localparam int NREQ_DEF     = 4;
    localparam int IDW_DEF      = 2;
    localparam int MULT_LAT_DEF = 2;
    localparam int CNTW_DEF     = 4;

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap-around
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // walk offsets from farthest to nearest so the first requester at or above ptr wins
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NREQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

    // any request pending
    always_comb any = |req;

endmodule

// File: rtl/mult_sched.sv
// mult_sched: round-robin sharing of one signed multiplier among NREQ requesters
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int MBITS    = MBITS_DEF,
    parameter int NBITS    = NBITS_DEF,
    parameter int NREQ     = NREQ_DEF,
    parameter int IDW      = IDW_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int CNTW     = CNTW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*MBITS-1:0]   req_mpd,
    input  logic [NREQ*NBITS-1:0]   req_mpr,
    output logic [MBITS-1:0]        mult_mpd,
    output logic [NBITS-1:0]        mult_mpr,
    output logic                    mult_start,
    input  logic [MBITS+NBITS-1:0]  mult_answer,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [MBITS+NBITS-1:0]  resp_data,
    output logic [IDW-1:0]          resp_id,
    output logic                    busy
);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [CNTW-1:0] cnt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  idx;
    logic            any;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    // grant is only offered while idle; busy mirrors the state so reset drops it at once
    always_comb begin
        req_ready = (state == IDLE) ? gnt : '0;
        busy      = state != IDLE;
    end

    // scheduler FSM: accept, set up operands, pulse start, wait fixed latency, hold response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            mult_mpd   <= '0;
            mult_mpr   <= '0;
            mult_start <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    mult_mpd <= req_mpd[idx*MBITS +: MBITS];
                    mult_mpr <= req_mpr[idx*NBITS +: NBITS];
                    resp_id  <= idx;
                    rr_ptr   <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
                    state    <= SETUP;
                end
                SETUP: begin
                    mult_start <= 1'b1;
                    state      <= FIRE;
                end
                FIRE: begin
                    mult_start <= 1'b0;
                    cnt        <= CNTW'(MULT_LAT - 1);
                    state      <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    resp_data  <= mult_answer;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed checks of the multiplier scheduler at MULT_LAT=2 and MULT_LAT=5
module tb_mult_sched;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req_valid, req_ready;
    logic [47:0] req_mpd;
    logic [31:0] req_mpr;
    logic [11:0] mult_mpd;
    logic [7:0]  mult_mpr;
    logic        mult_start;
    logic [19:0] mult_answer;
    logic        resp_valid, resp_ready;
    logic [19:0] resp_data;
    logic [1:0]  resp_id;
    logic        busy;

    logic [3:0]  req_valid_5, req_ready_5;
    logic [47:0] req_mpd_5;
    logic [31:0] req_mpr_5;
    logic [11:0] mult_mpd_5;
    logic [7:0]  mult_mpr_5;
    logic        mult_start_5;
    logic [19:0] mult_answer_5;
    logic        resp_valid_5, resp_ready_5;
    logic [19:0] resp_data_5;
    logic [1:0]  resp_id_5;
    logic        busy_5;

    int n_assert = 0;
    int n_fail   = 0;
    int k0 = 0;
    int k5 = 0;

    mult_sched u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mpd(req_mpd), .req_mpr(req_mpr),
        .mult_mpd(mult_mpd), .mult_mpr(mult_mpr), .mult_start(mult_start), .mult_answer(mult_answer),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
        .busy(busy)
    );

    mult_sched #(.MULT_LAT(5)) u5 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_5), .req_ready(req_ready_5), .req_mpd(req_mpd_5), .req_mpr(req_mpr_5),
        .mult_mpd(mult_mpd_5), .mult_mpr(mult_mpr_5), .mult_start(mult_start_5), .mult_answer(mult_answer_5),
        .resp_valid(resp_valid_5), .resp_ready(resp_ready_5), .resp_data(resp_data_5), .resp_id(resp_id_5),
        .busy(busy_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mul20(input logic signed [11:0] a, input logic signed [7:0] b);
        logic signed [19:0] x, y;
        x = a;
        y = b;
        return x * y;
    endfunction

    // multiplier models: junk after the start pulse, correct product only on the last cycle before capture
    always @(posedge clk) begin
        if (mult_start) begin
            mult_answer <= 20'hA5A5A;
            k0 <= 2 - 1;
        end else if (k0 != 0) begin
            k0 <= k0 - 1;
            if (k0 == 1) mult_answer <= mul20(mult_mpd, mult_mpr);
        end
    end

    always @(posedge clk) begin
        if (mult_start_5) begin
            mult_answer_5 <= 20'hA5A5A;
            k5 <= 5 - 1;
        end else if (k5 != 0) begin
            k5 <= k5 - 1;
            if (k5 == 1) mult_answer_5 <= mul20(mult_mpd_5, mult_mpr_5);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [11:0] a, input logic [7:0] b);
        req_valid[i]       = 1'b1;
        req_mpd[i*12 +: 12] = a;
        req_mpr[i*8 +: 8]   = b;
    endtask

    logic [11:0] ta [4] = '{12'h7FF, 12'h800, 12'h001, 12'h123};
    logic [7:0]  tb [4] = '{8'h7F, 8'h80, 8'hFF, 8'h10};
    logic [19:0] tp [4] = '{20'h3F781, 20'h40000, 20'hFFFFF, 20'h01230};

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_mpd = '0; req_mpr = '0; resp_ready = 1'b0;
        req_valid_5 = '0; req_mpd_5 = '0; req_mpr_5 = '0; resp_ready_5 = 1'b0;
        mult_answer = 20'h5A5A5; mult_answer_5 = 20'h5A5A5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", mult_start, 0);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rdata", resp_data, 0);
        chk("rst_rid", resp_id, 0);
        chk("rst_mpd", mult_mpd, 0);
        chk("rst_mpr", mult_mpr, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // single request from requester 0
        set_req(0, 12'h064, 8'h03);
        #1 chk("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        chk("t1_busy", busy, 1);
        chk("t1_mpd", mult_mpd, 12'h064);
        chk("t1_mpr", mult_mpr, 8'h03);
        chk("t1_setup_start", mult_start, 0);
        chk("t1_ready_off", req_ready, 0);
        step();
        chk("t1_fire_start", mult_start, 1);
        step();
        chk("t1_wait_start", mult_start, 0);
        step();
        chk("t1_early_valid", resp_valid, 0);
        step();
        chk("t1_valid", resp_valid, 1);
        chk("t1_data", resp_data, 20'h0012C);
        chk("t1_id", resp_id, 0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t1_done_valid", resp_valid, 0);
        chk("t1_done_busy", busy, 0);

        // signed operands from requester 2
        set_req(2, 12'hFFB, 8'h07);
        #1 chk("t2_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (3) step();
        chk("t2_early_valid", resp_valid, 0);
        step();
        chk("t2_valid", resp_valid, 1);
        chk("t2_data", resp_data, 20'hFFFDD);
        chk("t2_id", resp_id, 2);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // all four requesters continuously valid, fresh round-robin pointer
        rst_n = 1'b0;
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) set_req(i, ta[i], tb[i]);
        resp_ready = 1'b1;
        #1;
        for (int t = 0; t < 5; t++) begin
            chk("t3_ready", req_ready, 32'(1 << (t % 4)));
            step();
            chk("t3_busy", busy, 1);
            chk("t3_lat_id", resp_id, t % 4);
            for (int s = 0; s < 3; s++) begin
                step();
                chk("t3_busy_w", busy, 1);
                chk("t3_early_valid", resp_valid, 0);
            end
            step();
            chk("t3_valid", resp_valid, 1);
            chk("t3_data", resp_data, tp[t % 4]);
            chk("t3_id", resp_id, t % 4);
            step();
            chk("t3_done_valid", resp_valid, 0);
        end
        req_valid = '0;
        resp_ready = 1'b0;

        // response backpressure with requester 1 pending
        set_req(3, 12'h00A, 8'hFE);
        #1 chk("t4_ready3", req_ready, 4'b1000);
        step();
        req_valid = '0;
        set_req(1, 12'h005, 8'h05);
        #1 chk("t4_ready_busy", req_ready, 0);
        repeat (4) step();
        chk("t4_valid", resp_valid, 1);
        chk("t4_data", resp_data, 20'hFFFEC);
        chk("t4_id", resp_id, 3);
        for (int s = 0; s < 10; s++) begin
            step();
            chk("t4_hold_valid", resp_valid, 1);
            chk("t4_hold_data", resp_data, 20'hFFFEC);
            chk("t4_hold_id", resp_id, 3);
            chk("t4_hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t4_hs_valid", resp_valid, 0);
        chk("t4_hs_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        chk("t4_acc_busy", busy, 1);
        chk("t4_acc_id", resp_id, 1);
        chk("t4_acc_mpd", mult_mpd, 12'h005);
        repeat (4) step();
        chk("t4_valid1", resp_valid, 1);
        chk("t4_data1", resp_data, 20'h00019);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t4_done_busy", busy, 0);

        // reset while the start pulse is high
        set_req(3, 12'h010, 8'h02);
        #1 chk("t5_ready3", req_ready, 4'b1000);
        step();
        req_valid = '0;
        step();
        chk("t5_fire", mult_start, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_start", mult_start, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", resp_valid, 0);
        repeat (2) step();
        chk("t5_no_resp", resp_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        set_req(1, 12'h0FF, 8'h02);
        req_valid[3] = 1'b1;
        #1 chk("t5_ptr0_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        chk("t5_acc_id", resp_id, 1);
        repeat (4) step();
        chk("t5_valid", resp_valid, 1);
        chk("t5_data", resp_data, 20'h001FE);
        chk("t5_id", resp_id, 1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // MULT_LAT=5 instance: no early capture
        req_valid_5[0] = 1'b1;
        req_mpd_5[11:0] = 12'hFFF;
        req_mpr_5[7:0] = 8'h80;
        #1 chk("t6_ready", req_ready_5, 4'b0001);
        step();
        req_valid_5 = '0;
        for (int s = 1; s <= 6; s++) begin
            step();
            chk("t6_early_valid", resp_valid_5, 0);
            chk("t6_early_data", resp_data_5, 0);
        end
        step();
        chk("t6_valid", resp_valid_5, 1);
        chk("t6_data", resp_data_5, 20'h00080);
        chk("t6_id", resp_id_5, 0);
        resp_ready_5 = 1'b1;
        step();
        resp_ready_5 = 1'b0;
        chk("t6_done_valid", resp_valid_5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
